// File: rtl/soda_pkg.sv
// Shared types and defaults for the soda change-return path: denominations,
// FSM state encoding and the ack-timeout counter sizing helper.
package soda_pkg;

  localparam int unsigned D0_DEF      = 25;
  localparam int unsigned D1_DEF      = 10;
  localparam int unsigned D2_DEF      = 5;
  localparam int unsigned TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEL   = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

  localparam int unsigned CNT_W_DEF = cnt_width(TIMEOUT_DEF);

endpackage

// File: rtl/soda_coin_select.sv
// Greedy coin pick: largest denomination not exceeding the balance.
// Purely combinational; coin_ok is low when the balance is below the smallest coin.
module soda_coin_select
  import soda_pkg::*;
#(
  parameter int unsigned W  = 8,
  parameter int unsigned D0 = D0_DEF,
  parameter int unsigned D1 = D1_DEF,
  parameter int unsigned D2 = D2_DEF
) (
  input  logic [W-1:0] bal,
  output logic         coin_ok,
  output logic [W-1:0] coin_val
);

  localparam logic [W-1:0] D0_W = W'(D0);
  localparam logic [W-1:0] D1_W = W'(D1);
  localparam logic [W-1:0] D2_W = W'(D2);

  always_comb begin
    coin_ok  = 1'b1;
    coin_val = '0;
    if (bal >= D0_W) begin
      coin_val = D0_W;
    end else if (bal >= D1_W) begin
      coin_val = D1_W;
    end else if (bal >= D2_W) begin
      coin_val = D2_W;
    end else begin
      coin_ok = 1'b0;
    end
  end

endmodule

// File: rtl/soda_change_return.sv
// Change-return transmitter: pays a latched amount as a train of coin strobes,
// each held until the hopper acks or the ack timeout aborts the payout.
module soda_change_return
  import soda_pkg::*;
#(
  parameter int unsigned W       = 8,
  parameter int unsigned D0      = D0_DEF,
  parameter int unsigned D1      = D1_DEF,
  parameter int unsigned D2      = D2_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] amt,
  input  logic         coin_ack,
  output logic         coin_c,
  output logic [W-1:0] coin_a,
  output logic         busy,
  output logic         done,
  output logic         fault,
  output logic [W-1:0] rem
);

  localparam int unsigned CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e         state_q, state_d;
  logic [W-1:0]   bal_q, bal_d;
  logic [W-1:0]   rem_q, rem_d;
  logic [W-1:0]   coin_a_q, coin_a_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           coin_c_q, coin_c_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           fault_q, fault_d;

  logic           sel_ok;
  logic [W-1:0]   sel_val;

  soda_coin_select #(
    .W  (W),
    .D0 (D0),
    .D1 (D1),
    .D2 (D2)
  ) u_coin_select (
    .bal      (bal_q),
    .coin_ok  (sel_ok),
    .coin_val (sel_val)
  );

  always_comb begin
    state_d  = state_q;
    bal_d    = bal_q;
    rem_d    = rem_q;
    coin_a_d = coin_a_q;
    cnt_d    = cnt_q;
    coin_c_d = coin_c_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    fault_d  = fault_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          bal_d   = amt;
          fault_d = 1'b0;
          rem_d   = '0;
          busy_d  = 1'b1;
          state_d = SEL;
        end
      end
      SEL: begin
        if (sel_ok) begin
          coin_c_d = 1'b1;
          coin_a_d = sel_val;
          cnt_d    = '0;
          state_d  = ISSUE;
        end else begin
          rem_d   = bal_q;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      ISSUE: begin
        // An ack on the final timeout edge still pays the coin.
        if (coin_ack) begin
          bal_d    = bal_q - coin_a_q;
          coin_c_d = 1'b0;
          coin_a_d = '0;
          state_d  = SEL;
        end else if (cnt_q == CNT_LAST) begin
          fault_d  = 1'b1;
          rem_d    = bal_q;
          coin_c_d = 1'b0;
          coin_a_d = '0;
          done_d   = 1'b1;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      bal_q    <= '0;
      rem_q    <= '0;
      coin_a_q <= '0;
      cnt_q    <= '0;
      coin_c_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      bal_q    <= bal_d;
      rem_q    <= rem_d;
      coin_a_q <= coin_a_d;
      cnt_q    <= cnt_d;
      coin_c_q <= coin_c_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      fault_q  <= fault_d;
    end
  end

  assign coin_c = coin_c_q;
  assign coin_a = coin_a_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign fault  = fault_q;
  assign rem    = rem_q;

endmodule
